// File: rtl/matmul_seq.sv
// Sequential fixed-point matrix multiplier C = A x B: one multiply-accumulate per cycle, results streamed row-major.
// Optional build macro MATMUL_SAT_EN: saturate results to the signed DATA_WIDTH range instead of wrapping.
module matmul_seq #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8,
  parameter int ROW_1      = 8,
  parameter int COL_1      = 4,
  parameter int COL_2      = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic [DATA_WIDTH*ROW_1*COL_1-1:0]   in_1,
  input  logic [DATA_WIDTH*COL_1*COL_2-1:0]   in_2,
  output logic                                busy,
  output logic [DATA_WIDTH-1:0]               out_data,
  output logic [$clog2(ROW_1)-1:0]            out_row,
  output logic [$clog2(COL_2)-1:0]            out_col,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic                                done
);

  localparam int DW  = DATA_WIDTH;
  localparam int RW  = $clog2(ROW_1);
  localparam int CW  = $clog2(COL_2);
  localparam int KW  = (COL_1 > 1) ? $clog2(COL_1) : 1;
  localparam int AW  = 2*DW + $clog2(COL_1);
  localparam int NA  = ROW_1*COL_1;
  localparam int NB  = COL_1*COL_2;
  localparam int AIW = (NA > 1) ? $clog2(NA) : 1;
  localparam int BIW = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic [1:0] {IDLE, RUN, EMIT, DONE} state_t;

  state_t state, state_n;

  logic signed [DW-1:0] a_mem [NA];
  logic signed [DW-1:0] b_mem [NB];

  logic [RW-1:0]        i;
  logic [CW-1:0]        j;
  logic [KW-1:0]        k;
  logic signed [AW-1:0] acc;

  logic                 start_job, mac, fire, last_k, last_col, last_elem;
  logic [AIW-1:0]       a_idx;
  logic [BIW-1:0]       b_idx;
  logic signed [2*DW-1:0] prod;

  assign start_job = (state == IDLE) && start;
  assign mac       = (state == RUN);
  assign fire      = (state == EMIT) && out_ready;
  assign last_k    = (k == KW'(COL_1-1));
  assign last_col  = (j == CW'(COL_2-1));
  assign last_elem = (i == RW'(ROW_1-1)) && last_col;

  assign a_idx = AIW'(int'(i)*COL_1 + int'(k));
  assign b_idx = BIW'(int'(k)*COL_2 + int'(j));
  assign prod  = a_mem[a_idx] * b_mem[b_idx];

  // NOTE: sequential blocks use non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // NOTE: defaults first in always_comb; any path leaving state_n unassigned would infer a latch.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = RUN;
      RUN:     if (last_k) state_n = EMIT;
      EMIT:    if (out_ready) state_n = last_elem ? DONE : RUN;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // NOTE: operand arrays get an explicit reset loop; a plain RAM inference would not clear on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < NA; n++) a_mem[n] <= '0;
      for (int n = 0; n < NB; n++) b_mem[n] <= '0;
    end else if (start_job) begin
      for (int n = 0; n < NA; n++) a_mem[n] <= in_1[DW*n +: DW];
      for (int n = 0; n < NB; n++) b_mem[n] <= in_2[DW*n +: DW];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i   <= '0;
      j   <= '0;
      k   <= '0;
      acc <= '0;
    end else if (start_job) begin
      i   <= '0;
      j   <= '0;
      k   <= '0;
      acc <= '0;
    end else if (mac) begin
      acc <= acc + AW'(prod);
      k   <= last_k ? '0 : k + KW'(1);
    end else if (fire) begin
      k   <= '0;
      acc <= '0;
      if (!last_elem) begin
        if (last_col) begin
          j <= '0;
          i <= i + RW'(1);
        end else begin
          j <= j + CW'(1);
        end
      end
    end
  end

`ifdef MATMUL_SAT_EN
  localparam logic signed [AW-1:0] MAX_V = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [AW-1:0] MIN_V = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};
  logic signed [AW-1:0] shifted;

  assign shifted = acc >>> FRAC_BITS;

  always_comb begin
    if (shifted > MAX_V)      out_data = {1'b0, {(DW-1){1'b1}}};
    else if (shifted < MIN_V) out_data = {1'b1, {(DW-1){1'b0}}};
    else                      out_data = shifted[DW-1:0];
  end
`else
  // Wrap-around: keep the low DATA_WIDTH bits of the floor-shifted sum.
  assign out_data = DW'(acc >>> FRAC_BITS);
`endif

  // Everything below derives from reset-cleared registers, so reset zeroes it without a clock.
  assign out_row   = i;
  assign out_col   = j;
  assign busy      = (state != IDLE);
  assign out_valid = (state == EMIT);
  assign done      = (state == DONE);

endmodule

// File: tb/tb_matmul_seq.sv
// Self-checking bench for matmul_seq: table of uniform-operand jobs, a stalled random job,
// ignored-start and mid-job reset sequences, all checked through an expected-result queue.
module tb_matmul_seq;

  localparam int DW = 16;
  localparam int FB = 8;
  localparam int R  = 8;
  localparam int C1 = 4;
  localparam int C2 = 8;
  localparam int AB = DW*R*C1;
  localparam int BB = DW*C1*C2;
  localparam int BUDGET = 3000;

`ifdef MATMUL_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          out_ready = 1'b0;
  logic [AB-1:0] in_1 = '0;
  logic [BB-1:0] in_2 = '0;
  logic          busy, out_valid, done;
  logic [DW-1:0] out_data;
  logic [2:0]    out_row, out_col;

  always #5 clk = ~clk;

  matmul_seq #(
    .DATA_WIDTH(DW), .FRAC_BITS(FB), .ROW_1(R), .COL_1(C1), .COL_2(C2)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .in_1(in_1), .in_2(in_2),
    .busy(busy), .out_data(out_data), .out_row(out_row), .out_col(out_col),
    .out_valid(out_valid), .out_ready(out_ready), .done(done)
  );

  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] c;
  } vec_t;

  typedef struct {
    int            row;
    int            col;
    logic [DW-1:0] data;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] conv(input longint sum);
    longint sh;
    sh = sum >>> FB;
    if (SAT && sh > 64'sd32767)  return 16'h7FFF;
    if (SAT && sh < -64'sd32768) return 16'h8000;
    return sh[DW-1:0];
  endfunction

  task automatic push_model(input logic [AB-1:0] a, input logic [BB-1:0] b);
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C2; c++) begin
        longint s;
        exp_t   e;
        s = 0;
        for (int kk = 0; kk < C1; kk++)
          s += longint'($signed(a[(r*C1+kk)*DW +: DW])) * longint'($signed(b[(kk*C2+c)*DW +: DW]));
        e.row = r; e.col = c; e.data = conv(s);
        sb.push_back(e);
      end
  endtask

  task automatic push_uniform(input logic [DW-1:0] c);
    for (int r = 0; r < R; r++)
      for (int cc = 0; cc < C2; cc++) begin
        exp_t e;
        e.row = r; e.col = cc; e.data = c;
        sb.push_back(e);
      end
  endtask

  function automatic logic [AB-1:0] fill_a(input logic [DW-1:0] v);
    logic [AB-1:0] m;
    for (int n = 0; n < R*C1; n++) m[n*DW +: DW] = v;
    return m;
  endfunction

  function automatic logic [BB-1:0] fill_b(input logic [DW-1:0] v);
    logic [BB-1:0] m;
    for (int n = 0; n < C1*C2; n++) m[n*DW +: DW] = v;
    return m;
  endfunction

  function automatic logic [AB-1:0] rand_a();
    logic [AB-1:0] m;
    for (int w = 0; w < AB/32; w++) m[w*32 +: 32] = $urandom();
    return m;
  endfunction

  function automatic logic [BB-1:0] rand_b();
    logic [BB-1:0] m;
    for (int w = 0; w < BB/32; w++) m[w*32 +: 32] = $urandom();
    return m;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},      busy,      0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_done"},      done,      0);
    check({tag, "_out_data"},  out_data,  0);
    check({tag, "_out_row"},   out_row,   0);
    check({tag, "_out_col"},   out_col,   0);
  endtask

  // Runs one job from IDLE; expected results must already be queued.
  task automatic run_job(input logic [AB-1:0] a, input logic [BB-1:0] b,
                         input bit rand_ready, input bit scramble, input bit start_glitch);
    int            cyc, first_valid, n_out, n_done, n_extra;
    bit            stalled, finished;
    logic [DW-1:0] hd;
    logic [2:0]    hr, hc;
    exp_t          e;
    first_valid = -1; n_out = 0; n_done = 0; n_extra = 0;
    stalled = 0; finished = 0; hd = '0; hr = '0; hc = '0;
    in_1 = a; in_2 = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    while (!finished && cyc < BUDGET) begin
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (scramble) begin
        in_1 = rand_a();
        in_2 = rand_b();
      end
      if (start_glitch) start = (cyc == 2) || done;
      if (out_valid) begin
        if (first_valid < 0) first_valid = cyc;
        if (stalled) begin
          check("stall_data", out_data, hd);
          check("stall_row",  out_row,  hr);
          check("stall_col",  out_col,  hc);
        end
        if (out_ready) begin
          if (sb.size() == 0) begin
            check("extra_output", 1, 0);
          end else begin
            e = sb.pop_front();
            check("out_row",  out_row,  e.row);
            check("out_col",  out_col,  e.col);
            check("out_data", out_data, e.data);
          end
          n_out++;
          stalled = 0;
        end else begin
          stalled = 1;
          hd = out_data; hr = out_row; hc = out_col;
        end
      end
      if (done) begin
        n_done++;
        finished = 1;
        check("busy_in_done", busy, 1);
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    out_ready = 1'b0;
    check("job_finished", finished, 1);
    check("busy_after_done", busy, 0);
    for (int n = 0; n < 3; n++) begin
      if (done) n_done++;
      if (out_valid || busy) n_extra++;
      @(posedge clk); #1;
    end
    check("first_valid_cycle", first_valid, C1 + 1);
    check("output_count", n_out, R*C2);
    check("done_pulses", n_done, 1);
    check("idle_after_job", n_extra, 0);
    check("queue_drained", sb.size(), 0);
    sb.delete();
  endtask

  vec_t tbl[7];

  initial begin
    logic [AB-1:0] a;
    logic [BB-1:0] b;
    int            n_bad;

    tbl[0] = '{16'h0100, 16'h0100, 16'h0400};
    tbl[1] = '{16'hFF00, 16'h0200, 16'hF800};
    tbl[2] = '{16'h7F00, 16'h7F00, SAT ? 16'h7FFF : 16'h0400};
    tbl[3] = '{16'h0080, 16'h0080, 16'h0100};
    tbl[4] = '{16'h8000, 16'h8000, SAT ? 16'h7FFF : 16'h0000};
    tbl[5] = '{16'h8000, 16'h7F00, SAT ? 16'h8000 : 16'h0000};
    tbl[6] = '{16'hFFFF, 16'h0001, 16'hFFFF};

    #2 rst = 1'b1;
    #1 check_reset_outputs("por");
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int t = 0; t < 7; t++) begin
      push_uniform(tbl[t].c);
      run_job(fill_a(tbl[t].a), fill_b(tbl[t].b), 1'b0, 1'b0, 1'b0);
    end

    // Random operands, random back-pressure, operands scrambled after start.
    a = rand_a(); b = rand_b();
    push_model(a, b);
    run_job(a, b, 1'b1, 1'b1, 1'b0);

    // start pulsed during RUN and during DONE must not launch extra jobs.
    push_uniform(16'h0400);
    run_job(fill_a(16'h0100), fill_b(16'h0100), 1'b0, 1'b0, 1'b1);

    // Reset while an element is waiting in EMIT.
    in_1 = rand_a(); in_2 = rand_b(); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    out_ready = 1'b0;
    for (int n = 0; n < 20 && !out_valid; n++) begin
      @(posedge clk); #1;
    end
    check("reach_emit", out_valid, 1);
    rst = 1'b1;
    #1 check_reset_outputs("mid_reset");
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1'b0;
    n_bad = 0;
    for (int n = 0; n < 10; n++) begin
      @(posedge clk); #1;
      if (busy || out_valid || done) n_bad++;
    end
    check("quiet_after_reset", n_bad, 0);

    a = rand_a(); b = rand_b();
    push_model(a, b);
    run_job(a, b, 1'b1, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/matmul_seq.md
MATMUL_SEQ -- requirements
Module: matmul_seq

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: signed two's-complement element width for inputs and outputs.
REQ-002 SHALL have parameter FRAC_BITS, default 8: fractional bits in inputs and outputs (Q8.8 at defaults).
REQ-003 SHALL have parameter ROW_1, default 8: rows of matrix A.
REQ-004 SHALL have parameter COL_1, default 4: columns of A, equal to rows of B, and the dot-product length.
REQ-005 SHALL have parameter COL_2, default 8: columns of B.
REQ-006 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-007 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-008 SHALL have port start, input, 1 bit: job request, sampled only in IDLE.
REQ-009 SHALL have port in_1, input, DATA_WIDTH*ROW_1*COL_1 bits: matrix A, row-major; element (i,k) at flat index i*COL_1+k, occupying bits [DW*(idx+1)-1 : DW*idx].
REQ-010 SHALL have port in_2, input, DATA_WIDTH*COL_1*COL_2 bits: matrix B, row-major; element (k,j) at flat index k*COL_2+j.
REQ-011 SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-012 SHALL have port out_data, output, DATA_WIDTH bits: result element C(i,j).
REQ-013 SHALL have ports out_row and out_col, outputs, $clog2(ROW_1) and $clog2(COL_2) bits: indices i and j of out_data.
REQ-014 SHALL have port out_valid, output, 1 bit, and port out_ready, input, 1 bit: result stream handshake.
REQ-015 SHALL have port done, output, 1 bit: one-cycle pulse marking job completion.

Function
REQ-016 SHALL implement states IDLE, RUN, EMIT and DONE, with exactly one multiply-accumulate per RUN cycle.
REQ-017 In IDLE with start=1 at an edge: SHALL latch in_1 and in_2 into internal registers, clear i, j, k and the accumulator, and enter RUN; later changes on in_1/in_2 SHALL have no effect on the job.
REQ-018 In RUN: SHALL add A(i,k)*B(k,j) to the accumulator each cycle; after the k=COL_1-1 add, SHALL enter EMIT.
REQ-019 Accumulator SHALL be 2*DATA_WIDTH+$clog2(COL_1) bits, signed, so it never overflows.
REQ-020 Result conversion SHALL arithmetic-shift the accumulator right by FRAC_BITS (truncation toward minus infinity); narrowing to DATA_WIDTH bits follows REQ-031.
REQ-021 Latency: with start sampled at edge 0, RUN SHALL occupy cycles 1..COL_1, and out_valid SHALL first be high in cycle COL_1+1.
REQ-022 In EMIT: out_valid SHALL be 1; out_data, out_row and out_col SHALL stay stable until out_valid and out_ready are both high at an edge.
REQ-023 On a handshake when (i,j) is not the last element: SHALL advance j, and on j wrap (COL_2-1 to 0) SHALL advance i; SHALL clear k and the accumulator and return to RUN.
REQ-024 Output order SHALL be row-major: (0,0), (0,1), ... (ROW_1-1, COL_2-1), ROW_1*COL_2 outputs in total.
REQ-025 On the handshake of element (ROW_1-1, COL_2-1): SHALL enter DONE; in DONE, done=1 and busy=1 for one cycle, then IDLE.
REQ-026 start SHALL be ignored while busy=1, including in the DONE cycle; a new job needs start high in IDLE.
REQ-027 out_valid SHALL be 0 in all states except EMIT; out_ready SHALL be ignored outside EMIT.

Reset
REQ-028 While rst=1: state=IDLE and busy, out_valid, done, out_data, out_row and out_col SHALL all be 0, immediately and without waiting for a clock.
REQ-029 Reset asserted mid-job SHALL abort the job: no further outputs, no done pulse, and in_1/in_2 SHALL be relatched on the next start.
REQ-030 The latched operand registers and the accumulator SHALL also clear to 0 on reset.

Configuration
REQ-031 Macro MATMUL_SAT_EN: when defined, a shifted result above the signed DATA_WIDTH maximum SHALL output the maximum (0x7FFF) and one below the minimum SHALL output the minimum (0x8000); when undefined, the result SHALL be the low DATA_WIDTH bits (wrap-around).

Verification
REQ-032 All A and B elements 0x0100 (1.0), out_ready=1 -> 64 outputs of 0x0400 in row-major order, first out_valid in cycle 5 after start, done pulsed once.
REQ-033 A all 0xFF00 (-1.0), B all 0x0200 (2.0) -> every out_data 0xF800 (-8.0).
REQ-034 A and B all 0x7F00 (127.0) -> 0x7FFF with MATMUL_SAT_EN defined; 0x0400 without it.
REQ-035 out_ready toggled pseudo-randomly, operands changed after start -> out_data/out_row/out_col stable while stalled, no output lost or duplicated, results match the operands latched at start.
REQ-036 start pulsed during RUN and during DONE, then rst asserted for 1 cycle while in EMIT -> extra starts ignored; after reset all outputs 0, no done pulse, and a following start runs a clean full job.
